// File: rtl/next_pc_stage_pkg.sv
// Shared fetch-unit types, geometry constants and PC helper functions.
package next_pc_stage_pkg;

    localparam int unsigned FETCH_WIDTH            = 2;
    localparam int unsigned PC_WIDTH               = 32;
    localparam int unsigned INSN_BYTES             = 4;
    localparam int unsigned FETCH_GROUP_BYTES      = FETCH_WIDTH * INSN_BYTES;
    localparam int unsigned INSN_OFFSET_BITS       = $clog2(INSN_BYTES);
    localparam int unsigned FETCH_LANE_OFFSET_BITS = $clog2(FETCH_GROUP_BYTES);
    localparam int unsigned LANE_IDX_BITS          = FETCH_LANE_OFFSET_BITS - INSN_OFFSET_BITS;

    localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0000_1000);

    typedef enum logic [2:0] {
        SEL_FLUSH,
        SEL_DEC,
        SEL_PEND,
        SEL_HOLD,
        SEL_PRED,
        SEL_SEQ
    } next_pc_sel_e;

    typedef enum logic {
        NPC_BOOT,
        NPC_RUN
    } next_pc_state_e;

    // Winning taken-branch prediction of a fetch group.
    typedef struct packed {
        logic                hit;
        logic [PC_WIDTH-1:0] target;
    } pred_result_t;

    // Clear the byte-offset bits below instruction alignment.
    function automatic logic [PC_WIDTH-1:0] align_insn(input logic [PC_WIDTH-1:0] addr);
        return addr & ~PC_WIDTH'(INSN_BYTES - 1);
    endfunction

    // Start of the next fetch group; wraps modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] seq_pc(input logic [PC_WIDTH-1:0] addr);
        return (addr & ~PC_WIDTH'(FETCH_GROUP_BYTES - 1)) + PC_WIDTH'(FETCH_GROUP_BYTES);
    endfunction

    // Lanes at or above the entry lane of the group are valid.
    function automatic logic [FETCH_WIDTH-1:0] lane_mask(input logic [LANE_IDX_BITS-1:0] idx);
        logic [FETCH_WIDTH-1:0] m;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            m[i] = (LANE_IDX_BITS'(i) >= idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/next_pc_stage_if.sv
// Bus between the next-PC stage and the fetch stage / redirect sources.
interface next_pc_stage_if;
    import next_pc_stage_pkg::*;

    logic                            stall;
    logic                            flush;
    logic [PC_WIDTH-1:0]             flushPC;
    logic                            decRedirect;
    logic [PC_WIDTH-1:0]             decRedirectPC;
    logic [FETCH_WIDTH-1:0]          fetchValid;
    logic [FETCH_WIDTH-1:0]          btbHit;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] btbOut;
    logic [FETCH_WIDTH-1:0]          brPredTaken;
    logic [FETCH_WIDTH-1:0]          readIsRASPopBr;
    logic [FETCH_WIDTH*PC_WIDTH-1:0] rasOut;
    logic [PC_WIDTH-1:0]             pc;
    logic [FETCH_WIDTH-1:0]          laneValid;
    logic                            squashFetch;

    modport master (
        output stall, flush, flushPC, decRedirect, decRedirectPC,
               fetchValid, btbHit, btbOut, brPredTaken, readIsRASPopBr, rasOut,
        input  pc, laneValid, squashFetch
    );

    modport slave (
        input  stall, flush, flushPC, decRedirect, decRedirectPC,
               fetchValid, btbHit, btbOut, brPredTaken, readIsRASPopBr, rasOut,
        output pc, laneValid, squashFetch
    );

endinterface

// File: rtl/next_pc_stage_pred_select.sv
// Picks the lowest valid taken-and-hit lane and its RAS or BTB target.
module next_pc_pred_select
    import next_pc_stage_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0]          fetch_valid,
    input  logic [FETCH_WIDTH-1:0]          btb_hit,
    input  logic [FETCH_WIDTH-1:0]          br_pred_taken,
    input  logic [FETCH_WIDTH-1:0]          ras_pop,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] btb_out,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] ras_out,
    output pred_result_t                    result_c
);

    // Scan from the top lane down so the lowest taken lane is written last.
    always_comb begin
        result_c = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (fetch_valid[i] && btb_hit[i] && br_pred_taken[i]) begin
                result_c.hit    = 1'b1;
                result_c.target = ras_pop[i] ? ras_out[i*PC_WIDTH +: PC_WIDTH]
                                             : btb_out[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

endmodule

// File: rtl/next_pc_stage.sv
// Fetch PC register, redirect/prediction priority mux and lane-valid generation.
module next_pc_stage
    import next_pc_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    next_pc_stage_if.slave bus
);

    next_pc_state_e         state_q, state_d;
    next_pc_sel_e           sel;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [FETCH_WIDTH-1:0] lane_valid_q, lane_valid_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [PC_WIDTH-1:0]    pend_pc_q, pend_pc_d;
    logic                   squash_c;
    pred_result_t           pred_c;

    next_pc_pred_select u_pred_select (
        .fetch_valid   (bus.fetchValid),
        .btb_hit       (bus.btbHit),
        .br_pred_taken (bus.brPredTaken),
        .ras_pop       (bus.readIsRASPopBr),
        .btb_out       (bus.btbOut),
        .ras_out       (bus.rasOut),
        .result_c      (pred_c)
    );

    // Boot/run state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= NPC_BOOT;
        else      state_q <= state_d;
    end

    // Next state, next-PC priority selection and pending-redirect update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        lane_valid_d = lane_valid_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        sel          = SEL_HOLD;
        squash_c     = 1'b0;

        case (state_q)
            NPC_BOOT: begin
                state_d      = NPC_RUN;
                lane_valid_d = lane_mask(pc_q[FETCH_LANE_OFFSET_BITS-1:INSN_OFFSET_BITS]);
            end
            NPC_RUN: begin
                if (bus.flush)                        sel = SEL_FLUSH;
                else if (bus.decRedirect)             sel = SEL_DEC;
                else if (pend_valid_q && !bus.stall)  sel = SEL_PEND;
                else if (bus.stall)                   sel = SEL_HOLD;
                else if (pred_c.hit)                  sel = SEL_PRED;
                else                                  sel = SEL_SEQ;

                case (sel)
                    SEL_FLUSH: begin
                        pc_d         = align_insn(bus.flushPC);
                        pend_valid_d = 1'b0;
                        squash_c     = 1'b1;
                    end
                    SEL_DEC: begin
                        squash_c = 1'b1;
                        if (bus.stall) begin
                            pend_valid_d = 1'b1;
                            pend_pc_d    = align_insn(bus.decRedirectPC);
                        end else begin
                            pc_d         = align_insn(bus.decRedirectPC);
                            pend_valid_d = 1'b0;
                        end
                    end
                    SEL_PEND: begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                    end
                    SEL_PRED: pc_d = align_insn(pred_c.target);
                    SEL_SEQ:  pc_d = seq_pc(pc_q);
                    default:  pc_d = pc_q;
                endcase

                lane_valid_d = lane_mask(pc_d[FETCH_LANE_OFFSET_BITS-1:INSN_OFFSET_BITS]);
            end
            default: state_d = NPC_BOOT;
        endcase
    end

    // PC, lane-valid and pending-redirect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            lane_valid_q <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            lane_valid_q <= lane_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.laneValid   = lane_valid_q;
    assign bus.squashFetch = squash_c;

endmodule

// File: tb/tb_next_pc_stage.sv
// Directed bench for next_pc_stage: boot, redirects, prediction, pending and wrap.
module tb_next_pc_stage;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    next_pc_stage_if bus ();

    next_pc_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.flushPC        = '0;
        bus.decRedirect    = 1'b0;
        bus.decRedirectPC  = '0;
        bus.fetchValid     = '0;
        bus.btbHit         = '0;
        bus.btbOut         = '0;
        bus.brPredTaken    = '0;
        bus.readIsRASPopBr = '0;
        bus.rasOut         = '0;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic [1:0] exp_lv);
        chk({tag, "_pc"}, bus.pc, exp_pc);
        chk({tag, "_lv"}, 32'(bus.laneValid), 32'(exp_lv));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        clear_inputs();

        // Reset and boot
        tick(); tick();
        chk_pc("rst", 32'h0000_1000, 2'b00);
        chk("rst_sq", 32'(bus.squashFetch), 32'd0);
        rst = 1'b1;
        #1;
        chk("boot_lv", 32'(bus.laneValid), 32'd0);
        tick(); chk_pc("run0", 32'h0000_1000, 2'b11);
        tick(); chk_pc("run1", 32'h0000_1008, 2'b11);
        tick(); chk_pc("run2", 32'h0000_1010, 2'b11);

        // Unaligned flush
        bus.flush = 1'b1; bus.flushPC = 32'h0000_2004;
        #1 chk("flush_sq", 32'(bus.squashFetch), 32'd1);
        tick(); clear_inputs();
        #1 chk("flush_sq_off", 32'(bus.squashFetch), 32'd0);
        chk_pc("flush", 32'h0000_2004, 2'b10);
        tick(); chk_pc("flush_seq", 32'h0000_2008, 2'b11);

        // Lane priority
        bus.fetchValid = 2'b11; bus.btbHit = 2'b11; bus.brPredTaken = 2'b11;
        bus.btbOut = {32'h0000_3000, 32'h0000_4000};
        #1 chk("pred_sq", 32'(bus.squashFetch), 32'd0);
        tick(); chk_pc("pred_lane0", 32'h0000_4000, 2'b11);
        bus.fetchValid = 2'b10;
        tick(); clear_inputs(); chk_pc("pred_lane1", 32'h0000_3000, 2'b11);

        // RAS target overrides BTB target
        bus.fetchValid = 2'b01; bus.btbHit = 2'b01; bus.brPredTaken = 2'b01;
        bus.readIsRASPopBr = 2'b01;
        bus.btbOut = {32'h0000_0000, 32'h0000_6000};
        bus.rasOut = {32'h0000_0000, 32'h0000_5000};
        #1 chk("ras_sq", 32'(bus.squashFetch), 32'd0);
        tick(); clear_inputs(); chk_pc("ras", 32'h0000_5000, 2'b11);

        // Decode redirect under stall becomes pending
        bus.stall = 1'b1; bus.decRedirect = 1'b1; bus.decRedirectPC = 32'h0000_7000;
        #1 chk("pend_sq", 32'(bus.squashFetch), 32'd1);
        tick(); bus.decRedirect = 1'b0;
        #1 chk("pend_hold_sq", 32'(bus.squashFetch), 32'd0);
        chk_pc("pend_hold", 32'h0000_5000, 2'b11);
        tick(); chk_pc("pend_hold2", 32'h0000_5000, 2'b11);
        bus.stall = 1'b0;
        #1 chk("pend_apply_sq", 32'(bus.squashFetch), 32'd0);
        tick(); chk_pc("pend_apply", 32'h0000_7000, 2'b11);
        tick(); chk_pc("pend_seq", 32'h0000_7008, 2'b11);

        // Flush discards a pending redirect, even under stall
        bus.stall = 1'b1; bus.decRedirect = 1'b1; bus.decRedirectPC = 32'h0000_7000;
        tick(); bus.decRedirect = 1'b0;
        bus.flush = 1'b1; bus.flushPC = 32'h0000_8000;
        #1 chk("pflush_sq", 32'(bus.squashFetch), 32'd1);
        tick(); clear_inputs(); chk_pc("pflush", 32'h0000_8000, 2'b11);
        tick(); chk_pc("pflush_seq", 32'h0000_8008, 2'b11);

        // Wrap at top of address space
        bus.flush = 1'b1; bus.flushPC = 32'hFFFF_FFF8;
        tick(); clear_inputs(); chk_pc("wrap_pre", 32'hFFFF_FFF8, 2'b11);
        tick(); chk_pc("wrap", 32'h0000_0000, 2'b11);

        // Simultaneous flush and decode redirect
        bus.flush = 1'b1; bus.flushPC = 32'h0000_9000;
        bus.decRedirect = 1'b1; bus.decRedirectPC = 32'h0000_A000;
        tick(); clear_inputs(); chk_pc("simul", 32'h0000_9000, 2'b11);
        tick(); chk_pc("simul_seq", 32'h0000_9008, 2'b11);

        // Sub-instruction low bits dropped
        bus.decRedirect = 1'b1; bus.decRedirectPC = 32'h0000_2006;
        tick(); clear_inputs(); chk_pc("align", 32'h0000_2004, 2'b10);

        // Reset during a pending redirect
        bus.stall = 1'b1; bus.decRedirect = 1'b1; bus.decRedirectPC = 32'h0000_B000;
        tick(); clear_inputs();
        rst = 1'b0;
        #1 chk_pc("rst_pend", 32'h0000_1000, 2'b00);
        tick(); rst = 1'b1;
        #1 chk("reboot_lv", 32'(bus.laneValid), 32'd0);
        tick(); chk_pc("reboot0", 32'h0000_1000, 2'b11);
        tick(); chk_pc("reboot1", 32'h0000_1008, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
